light_phase_sequencer: RTL and testbench

Sequences the traffic-light phases of the final project: it steps GREEN -> YELLOW -> RED -> GREEN on one-second enables from `rate_divider`. It drives the 5-bit countdown value consumed by `countdown_hex_decoder` and the 3-bit active-low RGB colour code shared by the RGB LED and `colour_hex_decoder`. A pedestrian request shortens the green phase, with a single-cycle acknowledge.

---
 rtl/light_phase_sequencer.sv | 135 +++++++++++++
 tb/tb_light_phase_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/light_phase_sequencer.sv
// Traffic-light phase sequencer: IDLE -> GREEN -> YELLOW -> RED -> GREEN on one-second ticks.
// Drives the countdown value, the active-low RGB colour code and single-cycle
// phase-done / request-acknowledge pulses. All outputs are registered.
module light_phase_sequencer #(
  parameter int unsigned GREEN_TIME  = 20,
  parameter int unsigned YELLOW_TIME = 4,
  parameter int unsigned RED_TIME    = 15,
  parameter int unsigned REQ_CUT     = 5
) (
  input  logic       ClockIn,
  input  logic       Resetn,
  input  logic       Tick,
  input  logic       Start,
  input  logic       Stop,
  input  logic       Req,
  output logic [4:0] Count,
  output logic       CountEn,
  output logic [2:0] Colour,
  output logic [1:0] Phase,
  output logic       PhaseDone,
  output logic       ReqAck
);

  typedef enum logic [1:0] {
    PhIdle   = 2'b00,
    PhGreen  = 2'b01,
    PhYellow = 2'b10,
    PhRed    = 2'b11
  } phase_e;

  localparam logic [4:0] LdGreen  = 5'(GREEN_TIME);
  localparam logic [4:0] LdYellow = 5'(YELLOW_TIME);
  localparam logic [4:0] LdRed    = 5'(RED_TIME);
  localparam logic [4:0] LdCut    = 5'(REQ_CUT);

  localparam logic [2:0] ColGreen  = 3'b101;
  localparam logic [2:0] ColYellow = 3'b001;
  localparam logic [2:0] ColRed    = 3'b011;
  localparam logic [2:0] ColOff    = 3'b111;

  phase_e     r_phase;
  logic [4:0] r_count;
  logic       r_count_en;
  logic [2:0] r_colour;
  logic       r_phase_done;
  logic       r_req_ack;
  logic       r_req_pending;
  // Set when a pending request has lived through a GREEN phase; only such a request is
  // served at the YELLOW->RED edge. A request first raised in YELLOW waits for the next cycle.
  logic       r_req_armed;

  // Phase FSM with registered outputs; Stop > Start > request cut > Tick.
  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      r_phase       <= PhIdle;
      r_count       <= 5'd0;
      r_count_en    <= 1'b0;
      r_colour      <= ColOff;
      r_phase_done  <= 1'b0;
      r_req_ack     <= 1'b0;
      r_req_pending <= 1'b0;
      r_req_armed   <= 1'b0;
    end else begin
      r_phase_done <= 1'b0;
      r_req_ack    <= 1'b0;
      if (Stop) begin
        r_phase       <= PhIdle;
        r_count       <= 5'd0;
        r_count_en    <= 1'b0;
        r_colour      <= ColOff;
        r_req_pending <= 1'b0;
        r_req_armed   <= 1'b0;
      end else if (r_phase == PhIdle) begin
        if (Start) begin
          r_phase    <= PhGreen;
          r_count    <= LdGreen;
          r_count_en <= 1'b1;
          r_colour   <= ColGreen;
        end
      end else begin
        if (Req) begin
          r_req_pending <= 1'b1;
        end
        if (r_phase == PhGreen && r_req_pending && r_count > LdCut) begin
          // The cut wins over a simultaneous Tick.
          r_count <= LdCut;
        end else if (Tick) begin
          if (r_count > 5'd1) begin
            r_count <= r_count - 5'd1;
          end else begin
            r_phase_done <= 1'b1;
            case (r_phase)
              PhGreen: begin
                r_phase     <= PhYellow;
                r_count     <= LdYellow;
                r_colour    <= ColYellow;
                r_req_armed <= r_req_pending | Req;
              end
              PhYellow: begin
                r_phase  <= PhRed;
                r_count  <= LdRed;
                r_colour <= ColRed;
                if (r_req_armed) begin
                  // Overrides any Req seen this cycle: it belongs to the request being served.
                  r_req_pending <= 1'b0;
                  r_req_armed   <= 1'b0;
                  r_req_ack     <= 1'b1;
                end
              end
              PhRed: begin
                r_phase  <= PhGreen;
                r_count  <= LdGreen;
                r_colour <= ColGreen;
              end
              default: begin
                r_phase <= PhIdle;
              end
            endcase
          end
        end
      end
    end
  end

  // Outputs straight from the state registers.
  always_comb begin
    Phase     = r_phase;
    Count     = r_count;
    CountEn   = r_count_en;
    Colour    = r_colour;
    PhaseDone = r_phase_done;
    ReqAck    = r_req_ack;
  end

endmodule

// File: tb/tb_light_phase_sequencer.sv
// Self-checking bench for light_phase_sequencer: directed scenarios plus randomized traffic
// compared cycle by cycle against a phase-table reference model.
module tb_light_phase_sequencer;

  localparam int G = 20;
  localparam int Y = 4;
  localparam int R = 15;
  localparam int C = 5;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       req = 1'b0;
  logic [4:0] count;
  logic       count_en;
  logic [2:0] colour;
  logic [1:0] phase;
  logic       phase_done;
  logic       req_ack;
  logic [12:0] dut_vec;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase index 0=idle,1=green,2=yellow,3=red, plus request bookkeeping.
  int m_ph;
  int m_cnt;
  bit m_pend;
  bit m_armed;
  bit m_pd;
  bit m_ack;
  int ph_time[4] = '{0, G, Y, R};
  int ph_col[4]  = '{7, 5, 1, 3};

  light_phase_sequencer #(
    .GREEN_TIME (G),
    .YELLOW_TIME(Y),
    .RED_TIME   (R),
    .REQ_CUT    (C)
  ) dut (
    .ClockIn  (clk),
    .Resetn   (rstn),
    .Tick     (tick),
    .Start    (start),
    .Stop     (stop),
    .Req      (req),
    .Count    (count),
    .CountEn  (count_en),
    .Colour   (colour),
    .Phase    (phase),
    .PhaseDone(phase_done),
    .ReqAck   (req_ack)
  );

  always #5 clk = ~clk;

  assign dut_vec = {phase, count, count_en, colour, phase_done, req_ack};

  function automatic logic [12:0] exp_vec();
    return {2'(m_ph), 5'(m_cnt), (m_ph != 0), 3'(ph_col[m_ph]), m_pd, m_ack};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_pend = 0; m_armed = 0; m_pd = 0; m_ack = 0;
  endtask

  task automatic model_step(input bit t, input bit s, input bit p, input bit q);
    bit new_pend;
    m_pd = 0;
    m_ack = 0;
    if (p) begin
      model_reset();
    end else if (m_ph == 0) begin
      if (s) begin
        m_ph = 1;
        m_cnt = G;
      end
    end else begin
      new_pend = m_pend | q;
      if (m_ph == 1 && m_pend && m_cnt > C) begin
        m_cnt = C;
      end else if (t) begin
        if (m_cnt > 1) begin
          m_cnt = m_cnt - 1;
        end else begin
          m_pd = 1;
          if (m_ph == 1) m_armed = new_pend;
          if (m_ph == 2 && m_armed) begin
            m_ack = 1;
            new_pend = 0;
            m_armed = 0;
          end
          m_ph = (m_ph % 3) + 1;
          m_cnt = ph_time[m_ph];
        end
      end
      m_pend = new_pend;
    end
  endtask

  // One clock: drive inputs, update the model at the edge, sample 1 ns later.
  task automatic cycle(input bit t, input bit s, input bit p, input bit q);
    tick = t; start = s; stop = p; req = q;
    @(posedge clk);
    if (!rstn) model_reset();
    else model_step(t, s, p, q);
    #1;
    tick = 0; start = 0; stop = 0; req = 0;
  endtask

  // Tick until the model reaches the given phase/count; ok=0 if the budget ran out.
  task automatic advance(input int ph, input int cnt, output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (m_ph == ph && m_cnt == cnt) begin
        ok = 1;
        break;
      end
      cycle(1, 0, 0, 0);
    end
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if (phase !== 2'b00 || count !== 5'd0) begin
      n_fail++; $display("FAIL reset_phase_count: got %b/%0d want 00/0", phase, count);
    end
    n_tests++;
    if (count_en !== 1'b0 || colour !== 3'b111) begin
      n_fail++; $display("FAIL reset_en_colour: got %b/%b want 0/111", count_en, colour);
    end
    n_tests++;
    if (phase_done !== 1'b0 || req_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b/%b want 0/0", phase_done, req_ack);
    end
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    cycle(1, 0, 0, 1);
    n_tests++;
    if (phase !== 2'b00 || count !== 5'd0) begin
      n_fail++; $display("FAIL idle_ignores_tick_req: got %b/%0d want 00/0", phase, count);
    end
  endtask

  task automatic test_full_cycle();
    int pd_cnt;
    pd_cnt = 0;
    cycle(0, 1, 0, 0);
    n_tests++;
    if (phase !== 2'b01 || count !== 5'd20 || colour !== 3'b101 || phase_done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_green: got %b/%0d/%b/%b want 01/20/101/0", phase, count, colour,
               phase_done);
    end
    for (int i = 0; i < 78; i++) begin
      cycle(1, 0, 0, 0);
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL full_cycle step %0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (phase_done === 1'b1) pd_cnt++;
      if (i == 19) begin
        n_tests++;
        if (phase !== 2'b10 || count !== 5'd4 || colour !== 3'b001) begin
          n_fail++; $display("FAIL to_yellow: got %b/%0d/%b want 10/4/001", phase, count, colour);
        end
      end
      if (i == 23) begin
        n_tests++;
        if (phase !== 2'b11 || count !== 5'd15 || colour !== 3'b011) begin
          n_fail++; $display("FAIL to_red: got %b/%0d/%b want 11/15/011", phase, count, colour);
        end
      end
      if (i == 38) begin
        n_tests++;
        if (phase !== 2'b01 || count !== 5'd20 || colour !== 3'b101) begin
          n_fail++; $display("FAIL wrap_green: got %b/%0d/%b want 01/20/101", phase, count, colour);
        end
      end
    end
    n_tests++;
    if (pd_cnt != 6) begin
      n_fail++; $display("FAIL phase_done_count: got %0d want 6", pd_cnt);
    end
    cycle(0, 0, 1, 0);
  endtask

  task automatic test_req_cut();
    bit ok;
    int acks;
    acks = 0;
    cycle(0, 1, 0, 0);
    advance(1, 18, ok);
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 0);
    n_tests++;
    if (!ok || count !== 5'd5 || phase !== 2'b01) begin
      n_fail++; $display("FAIL req_cut: got %0d phase %b want 5 phase 01", count, phase);
    end
    for (int i = 0; i < 200; i++) begin
      cycle(1, 0, 0, 0);
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL req_cut_run step %0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (req_ack === 1'b1) acks++;
      if (m_ph == 3) break;
    end
    n_tests++;
    if (acks != 1 || req_ack !== 1'b1 || phase !== 2'b11) begin
      n_fail++; $display("FAIL req_ack_on_red: got acks %0d ack %b phase %b want 1/1/11", acks,
                         req_ack, phase);
    end
    cycle(0, 0, 0, 0);
    n_tests++;
    if (req_ack !== 1'b0) begin
      n_fail++; $display("FAIL req_ack_one_cycle: got %b want 0", req_ack);
    end
    cycle(0, 0, 1, 0);
  endtask

  task automatic test_req_late();
    bit ok;
    cycle(0, 1, 0, 0);
    advance(1, 3, ok);
    cycle(1, 0, 0, 1);
    n_tests++;
    if (!ok || count !== 5'd2 || phase !== 2'b01) begin
      n_fail++; $display("FAIL late_req_no_cut2: got %0d phase %b want 2 phase 01", count, phase);
    end
    cycle(1, 0, 0, 0);
    n_tests++;
    if (count !== 5'd1 || phase !== 2'b01) begin
      n_fail++; $display("FAIL late_req_no_cut1: got %0d phase %b want 1 phase 01", count, phase);
    end
    cycle(1, 0, 0, 0);
    advance(3, 15, ok);
    n_tests++;
    if (!ok || req_ack !== 1'b1 || phase !== 2'b11) begin
      n_fail++; $display("FAIL late_req_ack: got ack %b phase %b want 1/11", req_ack, phase);
    end
    cycle(0, 0, 1, 0);
  endtask

  task automatic test_req_tick_overlap();
    bit ok;
    int acks;
    int reds;
    acks = 0;
    reds = 0;
    cycle(0, 1, 0, 0);
    advance(1, 13, ok);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    n_tests++;
    if (!ok || count !== 5'd5) begin
      n_fail++; $display("FAIL cut_beats_tick: got %0d want 5", count);
    end
    for (int i = 0; i < 300; i++) begin
      cycle(1, 0, 0, i < 3);
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL overlap_run step %0d: got %b want %b", i, dut_vec, exp_vec());
      end
      if (req_ack === 1'b1) acks++;
      if (m_pd && m_ph == 3) reds++;
      if (reds == 2) break;
    end
    n_tests++;
    if (acks != 1) begin
      n_fail++; $display("FAIL single_ack: got %0d want 1", acks);
    end
    cycle(0, 0, 1, 0);
  endtask

  task automatic test_stop_yellow();
    bit ok;
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    advance(2, 3, ok);
    cycle(0, 0, 1, 0);
    n_tests++;
    if (!ok || phase !== 2'b00 || count !== 5'd0 || count_en !== 1'b0 || colour !== 3'b111 ||
        req_ack !== 1'b0) begin
      n_fail++; $display("FAIL stop_yellow: got %b/%0d/%b/%b/%b want 00/0/0/111/0", phase, count,
                         count_en, colour, req_ack);
    end
    cycle(0, 1, 1, 0);
    n_tests++;
    if (phase !== 2'b00 || count !== 5'd0) begin
      n_fail++; $display("FAIL start_stop_idle: got %b/%0d want 00/0", phase, count);
    end
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    n_tests++;
    if (phase !== 2'b01 || count !== 5'd20) begin
      n_fail++; $display("FAIL stop_clears_pending: got %b/%0d want 01/20", phase, count);
    end
    cycle(0, 0, 1, 0);
  endtask

  task automatic test_async_reset();
    bit ok;
    cycle(0, 1, 0, 0);
    advance(3, 7, ok);
    #3;
    rstn = 1'b0;
    #1;
    n_tests++;
    if (!ok || phase !== 2'b00 || count !== 5'd0 || count_en !== 1'b0 || colour !== 3'b111) begin
      n_fail++; $display("FAIL async_reset: got %b/%0d/%b/%b want 00/0/0/111", phase, count,
                         count_en, colour);
    end
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    cycle(0, 1, 0, 0);
    n_tests++;
    if (phase !== 2'b01 || count !== 5'd20 || colour !== 3'b101) begin
      n_fail++; $display("FAIL restart_after_reset: got %b/%0d/%b want 01/20/101", phase, count,
                         colour);
    end
  endtask

  task automatic test_random();
    bit t, s, p, q;
    cycle(0, 0, 1, 0);
    for (int i = 0; i < 4000; i++) begin
      t = ($urandom_range(0, 2) != 0);
      s = ($urandom_range(0, 9) == 0);
      p = ($urandom_range(0, 299) == 0);
      q = ($urandom_range(0, 29) == 0);
      cycle(t, s, p, q);
      n_tests++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random step %0d: got %b want %b", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_cycle();
    test_req_cut();
    test_req_late();
    test_req_tick_overlap();
    test_stop_yellow();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
